// File: rtl/voxel_pkg.sv
// -----------------------------------------------------------------------------
// voxel_pkg
// Shared constants, types and helpers for the cylindrical voxel writer.
//   - Volume geometry: ROTATIONAL_RESOLUTION x NUM_RADII words of Z_LEVELS bits.
//   - state_e   : writer controller states (CLEAR, RUN, DRAIN).
//   - stage_t   : one read-modify-write pipeline stage {valid, addr, mask}.
//   - wr_hist_t : a retired port-A write kept for forwarding {valid, addr, data}.
// -----------------------------------------------------------------------------
package voxel_pkg;

  localparam int ROTATIONAL_RESOLUTION = 64;
  localparam int NUM_RADII             = 32;
  localparam int Z_LEVELS              = 64;
  localparam int DEPTH                 = ROTATIONAL_RESOLUTION * NUM_RADII;
  localparam int ADDR_W                = $clog2(DEPTH);
  localparam int THETA_W               = $clog2(ROTATIONAL_RESOLUTION);
  localparam int RADIUS_W              = 6;
  localparam int Z_W                   = 6;
  localparam int RADIUS_IDX_W          = $clog2(NUM_RADII);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [ADDR_W-1:0]   addr;
    logic [Z_LEVELS-1:0] mask;
  } stage_t;

  typedef struct packed {
    logic                valid;
    logic [ADDR_W-1:0]   addr;
    logic [Z_LEVELS-1:0] data;
  } wr_hist_t;

  // Word address of a voxel column, computed at the full address width.
  function automatic logic [ADDR_W-1:0] voxel_addr(
    input logic [THETA_W-1:0]      theta,
    input logic [RADIUS_IDX_W-1:0] radius
  );
    return ADDR_W'(theta) * ADDR_W'(NUM_RADII) + ADDR_W'(radius);
  endfunction

  // One-hot bit for a z level inside a column word.
  function automatic logic [Z_LEVELS-1:0] z_mask(input logic [Z_W-1:0] z);
    logic [Z_LEVELS-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return one << z;
  endfunction

endpackage

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// -----------------------------------------------------------------------------
// xilinx_true_dual_port_read_first_1_clock_ram
// Single-clock dual-port RAM, read-first on both ports, optional output
// register (RAM_PERFORMANCE = "HIGH_PERFORMANCE" gives 2-cycle read latency,
// "LOW_LATENCY" gives 1 cycle). Contents are not initialised; the owner clears
// the array before use.
// Port A has a read address (addra) and a separate write address (wr_addra)
// so a read-modify-write pipe can read its newest beat and retire its oldest
// beat in the same cycle without stalling. Port B is a plain read/write port.
// Ports:
//   clka                      clock
//   addra / wr_addra          port A read / write address
//   dina, wea, ena            port A write data, write enable, port enable
//   rsta, regcea, douta       port A output-register reset/enable, read data
//   addrb, dinb, web, enb     port B address, write data, write/port enable
//   rstb, regceb, doutb       port B output-register reset/enable, read data
// -----------------------------------------------------------------------------
module xilinx_true_dual_port_read_first_1_clock_ram #(
  parameter int    RAM_WIDTH       = 64,
  parameter int    RAM_DEPTH       = 2048,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic                         clka,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [$clog2(RAM_DEPTH)-1:0] wr_addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         wea,
  input  logic                         ena,
  input  logic                         rsta,
  input  logic                         regcea,
  output logic [RAM_WIDTH-1:0]         douta,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]         dinb,
  input  logic                         web,
  input  logic                         enb,
  input  logic                         rstb,
  input  logic                         regceb,
  output logic [RAM_WIDTH-1:0]         doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data_a;
  logic [RAM_WIDTH-1:0] ram_data_b;

  // Array writes and read-first array reads for both ports.
  always_ff @(posedge clka) begin
    if (ena) begin
      ram_data_a <= mem[addra];
    end
    if (enb) begin
      ram_data_b <= mem[addrb];
    end
    if (ena && wea) begin
      mem[wr_addra] <= dina;
    end
    if (enb && web) begin
      mem[addrb] <= dinb;
    end
  end

  generate
    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
      assign douta = ram_data_a;
      assign doutb = ram_data_b;
    end else begin : g_out_reg
      logic [RAM_WIDTH-1:0] douta_reg;
      logic [RAM_WIDTH-1:0] doutb_reg;

      // Output pipeline registers with synchronous reset.
      always_ff @(posedge clka) begin
        if (rsta) begin
          douta_reg <= '0;
        end else if (regcea) begin
          douta_reg <= ram_data_a;
        end
        if (rstb) begin
          doutb_reg <= '0;
        end else if (regceb) begin
          doutb_reg <= ram_data_b;
        end
      end

      assign douta = douta_reg;
      assign doutb = doutb_reg;
    end
  endgenerate

endmodule

// File: rtl/cylindrical_voxel_writer.sv
// -----------------------------------------------------------------------------
// cylindrical_voxel_writer
// Sets one bit per accepted (theta, radius, z) voxel in a volume buffer whose
// words are Z columns (address = theta*NUM_RADII + radius). Port A of the RAM
// runs a 3-stage OR read-modify-write pipe (and the clear sweep); port B serves
// the display scan-out with a 2-cycle latency.
// Controller: CLEAR (DEPTH-cycle zero sweep) -> RUN -> DRAIN (3 cycles) -> CLEAR.
// Optional build macro VOXEL_WRITER_STATS_EN adds saturating voxel counters.
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   theta_in, radius_in,  voxel coordinates, qualified by data_valid_in
//   z_in, data_valid_in   (no backpressure; radius >= NUM_RADII is dropped)
//   clear_req             one-cycle request to clear the buffer (RUN only)
//   rd_addr, rd_data      display read port, 2-cycle latency
//   busy                  high while draining or clearing
//   frame_valid           high while buffer contents are coherent
//   voxels_written/_dropped (VOXEL_WRITER_STATS_EN only) beat counters
// -----------------------------------------------------------------------------
module cylindrical_voxel_writer
  import voxel_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [THETA_W-1:0]  theta_in,
  input  logic [RADIUS_W-1:0] radius_in,
  input  logic [Z_W-1:0]      z_in,
  input  logic                data_valid_in,
  input  logic                clear_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [Z_LEVELS-1:0] rd_data,
  output logic                busy,
  output logic                frame_valid
`ifdef VOXEL_WRITER_STATS_EN
  ,
  output logic [31:0]         voxels_written,
  output logic [31:0]         voxels_dropped
`endif
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic [1:0]          drain_q, drain_d;
  logic                clear_entry_s;
  logic                busy_q, frame_valid_q;

  stage_t              s0_s, s1_q, s2_q;
  wr_hist_t            w1_q, w2_q, w_new_s;
  logic                accept_s;
  logic [Z_LEVELS-1:0] douta_s;
  logic [Z_LEVELS-1:0] fwd_s;
  logic [Z_LEVELS-1:0] merged_s;

  logic                a_we_s;
  logic [ADDR_W-1:0]   a_waddr_s;
  logic [Z_LEVELS-1:0] a_wdata_s;

  // Controller next state: sweep counter in CLEAR, drain counter in DRAIN.
  always_comb begin
    state_d       = state_q;
    sweep_d       = sweep_q;
    drain_d       = drain_q;
    clear_entry_s = 1'b0;
    case (state_q)
      CLEAR: begin
        if (sweep_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RUN;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      RUN: begin
        if (clear_req) begin
          state_d = DRAIN;
          drain_d = 2'd0;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (drain_q == 2'd2) begin
          state_d       = CLEAR;
          sweep_d       = '0;
          clear_entry_s = 1'b1;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: begin
        state_d = CLEAR;
        sweep_d = '0;
      end
    endcase
  end

  // A clear_req in RUN claims the cycle, so a coincident beat is dropped.
  assign accept_s = (state_q == RUN) && data_valid_in && !clear_req &&
                    (radius_in < RADIUS_W'(NUM_RADII));

  // Stage 0: the beat as presented, with its address and one-hot mask.
  always_comb begin
    s0_s.valid = accept_s;
    s0_s.addr  = voxel_addr(theta_in, radius_in[RADIUS_IDX_W-1:0]);
    s0_s.mask  = z_mask(z_in);
  end

  // The S2 read snapshot predates the writes of the two preceding beats (one
  // lands on the same edge as the read, one after it), so their merged words
  // are ORed back in. Each retired word already contains older same-address
  // contributions, so two history entries cover every collision pattern.
  assign fwd_s    = ((w1_q.valid && (w1_q.addr == s2_q.addr)) ? w1_q.data : '0) |
                    ((w2_q.valid && (w2_q.addr == s2_q.addr)) ? w2_q.data : '0);
  assign merged_s = douta_s | s2_q.mask | fwd_s;

  always_comb begin
    w_new_s.valid = s2_q.valid;
    w_new_s.addr  = s2_q.addr;
    w_new_s.data  = merged_s;
  end

  // Port A write mux: zero sweep in CLEAR, retiring S2 beat otherwise.
  always_comb begin
    a_we_s    = 1'b0;
    a_waddr_s = s2_q.addr;
    a_wdata_s = merged_s;
    if (state_q == CLEAR) begin
      a_we_s    = 1'b1;
      a_waddr_s = sweep_q;
      a_wdata_s = '0;
    end else begin
      a_we_s    = s2_q.valid;
      a_waddr_s = s2_q.addr;
      a_wdata_s = merged_s;
    end
  end

  // Controller, pipeline and write-history registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= CLEAR;
      sweep_q       <= '0;
      drain_q       <= 2'd0;
      busy_q        <= 1'b1;
      frame_valid_q <= 1'b0;
      s1_q          <= '0;
      s2_q          <= '0;
      w1_q          <= '0;
      w2_q          <= '0;
    end else begin
      state_q       <= state_d;
      sweep_q       <= sweep_d;
      drain_q       <= drain_d;
      busy_q        <= (state_d != RUN);
      frame_valid_q <= (state_d == RUN);
      s1_q          <= s0_s;
      s2_q          <= s1_q;
      w1_q          <= w_new_s;
      w2_q          <= w1_q;
    end
  end

  assign busy        = busy_q;
  assign frame_valid = frame_valid_q;

  xilinx_true_dual_port_read_first_1_clock_ram #(
    .RAM_WIDTH       (Z_LEVELS),
    .RAM_DEPTH       (DEPTH),
    .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
  ) u_ram (
    .clka     (clk_in),
    .addra    (s0_s.addr),
    .wr_addra (a_waddr_s),
    .dina     (a_wdata_s),
    .wea      (a_we_s),
    .ena      (1'b1),
    .rsta     (rst_in),
    .regcea   (1'b1),
    .douta    (douta_s),
    .addrb    (rd_addr),
    .dinb     ({Z_LEVELS{1'b0}}),
    .web      (1'b0),
    .enb      (1'b1),
    .rstb     (rst_in),
    .regceb   (1'b1),
    .doutb    (rd_data)
  );

`ifdef VOXEL_WRITER_STATS_EN
  logic [31:0] written_q;
  logic [31:0] dropped_q;
  logic        drop_s;

  assign drop_s = data_valid_in && !accept_s;

  // Saturating beat counters, zeroed on reset and on entry to CLEAR.
  always_ff @(posedge clk_in) begin
    if (rst_in || clear_entry_s) begin
      written_q <= 32'd0;
      dropped_q <= 32'd0;
    end else begin
      if (accept_s && (written_q != 32'hFFFF_FFFF)) begin
        written_q <= written_q + 32'd1;
      end
      if (drop_s && (dropped_q != 32'hFFFF_FFFF)) begin
        dropped_q <= dropped_q + 32'd1;
      end
    end
  end

  assign voxels_written = written_q;
  assign voxels_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_cylindrical_voxel_writer.sv
module tb_cylindrical_voxel_writer;
  import voxel_pkg::*;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic [THETA_W-1:0]  theta_in;
  logic [RADIUS_W-1:0] radius_in;
  logic [Z_W-1:0]      z_in;
  logic                data_valid_in;
  logic                clear_req;
  logic [ADDR_W-1:0]   rd_addr;
  logic [Z_LEVELS-1:0] rd_data;
  logic                busy;
  logic                frame_valid;
`ifdef VOXEL_WRITER_STATS_EN
  logic [31:0]         voxels_written;
  logic [31:0]         voxels_dropped;
`endif

  cylindrical_voxel_writer dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .theta_in      (theta_in),
    .radius_in     (radius_in),
    .z_in          (z_in),
    .data_valid_in (data_valid_in),
    .clear_req     (clear_req),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .busy          (busy),
    .frame_valid   (frame_valid)
`ifdef VOXEL_WRITER_STATS_EN
    ,
    .voxels_written(voxels_written),
    .voxels_dropped(voxels_dropped)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Reference model: the volume as a plain array of column words.
  logic [63:0] model [2048];
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [5:0]  theta;
    logic [5:0]  radius;
    logic [5:0]  z;
    logic [10:0] chk_addr;
    logic [63:0] exp_word;
  } vec_t;
  vec_t tbl[8];

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2048; i++) model[i] = 64'd0;
  endtask

  // Present one beat for one cycle; the model applies the acceptance rule.
  task automatic beat(input int th, input int r, input int z);
    theta_in      = 6'(th);
    radius_in     = 6'(r);
    z_in          = 6'(z);
    data_valid_in = 1'b1;
    if (r < 32) model[th * 32 + r] = model[th * 32 + r] | (64'd1 << z);
    tick();
    data_valid_in = 1'b0;
  endtask

  task automatic read_word(input int a, output logic [63:0] d);
    rd_addr = 11'(a);
    tick();
    tick();
    d = rd_data;
  endtask

  // Pipelined scan of the whole buffer through port B against the model.
  task automatic scan(input string name);
    int errs;
    int first;
    logic [63:0] got;
    logic [63:0] want;
    errs  = 0;
    first = -1;
    got   = 64'd0;
    want  = 64'd0;
    for (int i = 0; i < 2048 + 2; i++) begin
      if (i >= 2 && rd_data !== model[i - 2]) begin
        errs++;
        if (first < 0) begin
          first = i - 2;
          got   = rd_data;
          want  = model[i - 2];
        end
      end
      if (i < 2048) rd_addr = 11'(i);
      tick();
    end
    if (errs != 0) $display("scan %s: first bad word %0d got %h want %h", name, first, got, want);
    check(name, 64'(errs), 64'd0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    logic [63:0] d;
    logic first_fv;

    tbl[0] = '{6'd3,  6'd5,  6'd7,  11'd101,  64'h80};
    tbl[1] = '{6'd3,  6'd5,  6'd0,  11'd101,  64'h81};
    tbl[2] = '{6'd63, 6'd31, 6'd63, 11'd2047, 64'h8000_0000_0000_0000};
    tbl[3] = '{6'd0,  6'd31, 6'd0,  11'd31,   64'h1};
    tbl[4] = '{6'd1,  6'd0,  6'd63, 11'd32,   64'h8000_0000_0000_0000};
    tbl[5] = '{6'd0,  6'd40, 6'd0,  11'd8,    64'h0};
    tbl[6] = '{6'd2,  6'd32, 6'd5,  11'd64,   64'h0};
    tbl[7] = '{6'd10, 6'd31, 6'd1,  11'd351,  64'h2};

    rst_in = 1'b1;
    theta_in = 6'd0; radius_in = 6'd0; z_in = 6'd0;
    data_valid_in = 1'b0; clear_req = 1'b0; rd_addr = 11'd0;
    model_clear();

    // One-cycle reset, then the full sweep.
    tick();
    rst_in = 1'b0;
    first_fv = frame_valid;
    check("reset_fv_low", 64'(first_fv), 64'd0);
    count_busy(n);
    check("reset_busy_len", 64'(n), 64'd2048);
    check("reset_fv_high", 64'(frame_valid), 64'd1);
    scan("reset_zero_scan");

`ifdef VOXEL_WRITER_STATS_EN
    beat(0, 40, 0);
    tick();
    check("stats_dropped", 64'(voxels_dropped), 64'd1);
    check("stats_written", 64'(voxels_written), 64'd0);
`endif

    // Table of single beats with hand-derived column words.
    for (int i = 0; i < 8; i++) begin
      beat(int'(tbl[i].theta), int'(tbl[i].radius), int'(tbl[i].z));
      tick();
      tick();
      read_word(int'(tbl[i].chk_addr), d);
      check($sformatf("tbl%0d", i), d, tbl[i].exp_word);
    end

    // Same address on consecutive cycles, then again after one idle cycle.
    beat(0, 0, 1);
    beat(0, 0, 2);
    beat(0, 0, 3);
    tick();
    beat(0, 0, 1);
    tick(); tick();
    read_word(0, d);
    check("b2b_word0", d, 64'hE);

    // Same address two cycles apart with another address between.
    beat(0, 7, 4);
    beat(0, 9, 0);
    beat(0, 7, 5);
    tick(); tick();
    read_word(7, d);
    check("gap2_word7", d, 64'h30);
    read_word(9, d);
    check("gap2_word9", d, 64'h1);

    // Randomised stream with a hot spot to force collisions.
    for (int i = 0; i < 800; i++) begin
      int th, r, z;
      if ($urandom_range(0, 1) == 0) begin
        th = int'($urandom_range(0, 1));
        r  = int'($urandom_range(0, 3));
      end else begin
        th = int'($urandom_range(0, 63));
        r  = int'($urandom_range(0, 39));
      end
      z = int'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 7) beat(th, r, z);
      else tick();
    end
    tick(); tick(); tick();
    scan("random_scan");

    // Clear mid-stream: beats keep coming through the busy window.
    for (int i = 0; i < 20; i++) beat(int'($urandom_range(0, 63)), int'($urandom_range(0, 31)), int'($urandom_range(0, 63)));
    theta_in = 6'd4; radius_in = 6'd4; z_in = 6'd4;
    data_valid_in = 1'b1;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    model_clear();
    first_fv = frame_valid;
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      theta_in  = 6'($urandom_range(0, 63));
      radius_in = 6'($urandom_range(0, 31));
      z_in      = 6'($urandom_range(0, 63));
      data_valid_in = 1'b1;
      n++;
      tick();
    end
    data_valid_in = 1'b0;
    check("clear_fv_low", 64'(first_fv), 64'd0);
    check("clear_busy_len", 64'(n), 64'd2051);
    scan("clear_zero_scan");
    beat(5, 6, 9);
    tick(); tick();
    read_word(166, d);
    check("post_clear_voxel", d, 64'h200);

    // Reset in the middle of the clear sweep restarts it from address 0.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 1003; i++) tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    model_clear();
    count_busy(n);
    check("midclear_reset_busy_len", 64'(n), 64'd2048);
    check("midclear_reset_fv", 64'(frame_valid), 64'd1);
    scan("midclear_zero_scan");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cylindrical_voxel_writer.md
Name: cylindrical_voxel_writer

Overview:
- Consumes the (theta, radius, z) stream from the Cartesian-to-cylindrical converter and sets one bit per voxel in a volume buffer.
- Buffer word = one Z column of bits; word address = theta*NUM_RADII + radius.
- Port A does the read-modify-write (OR) path; port B is a read-only port for the LED/slice scan-out driver.
- Also clears the buffer on reset and on request.

Parameters:
- ROTATIONAL_RESOLUTION, 64: theta slices.
- NUM_RADII, 32: radius bins; radius >= NUM_RADII is out of volume.
- Z_LEVELS, 64: word width, one bit per z.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- theta_in  input  $clog2(ROTATIONAL_RESOLUTION)  slice index
- radius_in  input  6  radial bin
- z_in  input  6  height
- data_valid_in  input  1  qualifies theta/radius/z for one cycle; no backpressure
- clear_req  input  1  one-cycle pulse requesting a buffer clear
- rd_addr  input  $clog2(ROTATIONAL_RESOLUTION*NUM_RADII)  display read address
- rd_data  output  Z_LEVELS  display word, 2-cycle latency
- busy  output  1  high while draining or clearing
- frame_valid  output  1  high when buffer contents are coherent (not clearing)

Behaviour:
- State machine: CLEAR -> RUN -> DRAIN -> CLEAR.
- Reset:
  - rst_in forces CLEAR with the sweep address at 0.
  - busy=1, frame_valid=0, pipeline valids=0.
  - rd_data resets to 0.
- CLEAR:
  - Writes 0 to port-A address k on cycle k, for k = 0..DEPTH-1 (DEPTH = ROTATIONAL_RESOLUTION*NUM_RADII).
  - Goes to RUN after the last address; busy falls and frame_valid rises on the first RUN cycle.
  - Sweep takes exactly DEPTH cycles.
  - clear_req is ignored in CLEAR and DRAIN.
  - Reset mid-sweep restarts the sweep at 0.
- RUN:
  - A beat is accepted when data_valid_in=1 and radius_in < NUM_RADII.
  - Rejected beats are dropped silently: no memory access, no stall.
  - Accepted beat, 3-stage pipe:
    - S0: issue read at addr, form mask = 1<<z_in.
    - S1/S2: RAM output latency.
    - S2: write (rdata | mask | forwarded) to addr.
- Hazard rule:
  - Final memory word must equal the OR of every accepted voxel to that address since the last clear.
  - This holds for any collision pattern, including the same address on consecutive cycles.
  - Implementation compares S0..S2 addresses against the in-flight writes and ORs in their merged words; no stalls.
- DRAIN:
  - Entered on clear_req in RUN; busy=1, frame_valid=0.
  - Lasts 3 cycles so in-flight writes retire; new beats are dropped.
  - Then goes to CLEAR at address 0.
  - A clear_req coincident with data_valid_in: that beat is dropped.
- Port B:
  - rd_data = mem[rd_addr] registered twice (2-cycle latency) in every state.
  - Contents are undefined while frame_valid=0.
- Width rules:
  - z_in is always < Z_LEVELS (6 bits, 64 levels).
  - Address = theta_in*NUM_RADII + radius_in[4:0], computed at the full address width.

Optional Feature:
- VOXEL_WRITER_STATS_EN
- Defined: adds outputs voxels_written[31:0] (accepted beats) and voxels_dropped[31:0] (data_valid_in beats rejected for radius or state).
  - Both are zeroed on rst_in and at CLEAR entry.
  - Both saturate at all-ones.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package voxel_pkg holds:
  - constants ROTATIONAL_RESOLUTION, NUM_RADII, Z_LEVELS, DEPTH, ADDR_W
  - the state enum {CLEAR, RUN, DRAIN}
  - the pipeline-stage struct {valid, addr, mask}
- Sub-module: xilinx_true_dual_port_read_first_1_clock_ram.
  - RAM_WIDTH = Z_LEVELS, RAM_DEPTH = DEPTH, HIGH_PERFORMANCE, no init file.
  - Port A: RMW/clear; port B: display read.

Test Plan:
- Reset: rst_in 1 cycle -> busy=1 for exactly 2048 cycles, frame_valid rises at cycle 2048, all rd_data reads = 0.
- Single voxel: theta=3, r=5, z=7, then rd_addr=101 -> rd_data=0x80 two cycles after the address.
- Back-to-back collision: theta=0/r=0 with z=1,2,3 on consecutive cycles, then 1 idle cycle, then z=1 again -> word 0 = 0xE.
- Out of range: radius=40, z=0 at theta=0 -> no address changes; stats build gives voxels_dropped=1.
- Clear mid-stream: voxels streaming, clear_req pulse -> busy high for 3+2048 cycles, beats in that window dropped, all words 0 afterwards, new voxels land normally.
- Reset during CLEAR at sweep address 1000 -> sweep restarts, busy lasts a full 2048 cycles from reset.
